// File: rtl/reverb_pkg.sv
// Shared types and constants for the reverb output stage.
//   sample_t : signed audio sample
//   mix_t    : wet/dry mix control word
//   prod_t   : registered dry/wet partial products between the two pipeline stages
package reverb_pkg;

    localparam int unsigned DW       = 16;
    localparam int unsigned MIX_W    = 6;
    localparam int unsigned MIX_FULL = 64;
    localparam int unsigned PROD_W   = DW + MIX_W + 1;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic [MIX_W-1:0]     mix_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] p_dry;
        logic signed [PROD_W-1:0] p_wet;
    } prod_t;

endpackage

// File: rtl/mix_gain_ramp.sv
// Slew-limited mix register: on each valid sample the applied mix moves toward
// the target by at most 'step', never overshooting; otherwise it holds.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (mix_cur -> 0)
//   in_valid  : sample strobe; the only cycles the mix may move
//   target    : requested mix
//   step      : maximum change per valid sample
//   mix_cur   : currently applied mix (registered)
module mix_gain_ramp
    import reverb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  mix_t target,
    input  mix_t step,
    output mix_t mix_cur
);

    mix_t diff_up_c;
    mix_t diff_dn_c;
    mix_t mix_nxt_c;

    // Next mix: clamp the step to the remaining distance so the target is hit exactly
    always_comb begin
        diff_up_c = target - mix_cur;
        diff_dn_c = mix_cur - target;
        mix_nxt_c = mix_cur;
        if (in_valid) begin
            if (mix_cur < target) begin
                mix_nxt_c = mix_cur + ((diff_up_c < step) ? diff_up_c : step);
            end else if (mix_cur > target) begin
                mix_nxt_c = mix_cur - ((diff_dn_c < step) ? diff_dn_c : step);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mix_cur <= '0;
        end else begin
            mix_cur <= mix_nxt_c;
        end
    end

endmodule

// File: rtl/reverb_wet_dry_mixer.sv
// Reverb output stage: blends dry and wet samples with a slew-limited mix,
// applies make-up gain, saturates to 16 bits and counts clipped samples.
// Two-cycle pipeline: products in stage 1, sum/shift/saturate in stage 2.
// Optional peak meter enabled by defining MIX_LIMITER_PEAK_EN.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : dry_in/wet_in valid strobe
//   dry_in      : signed dry sample
//   wet_in      : signed reverb sample
//   mix_target  : requested wet amount (0 = dry, 63 = 63/64 wet)
//   clip_clear  : synchronous clear of clip_count (wins over a clip)
//   out_valid   : audio_out strobe
//   audio_out   : mixed, saturated sample (holds between strobes)
//   mix_cur     : currently applied mix
//   clip        : pulses with out_valid when the output saturated
//   clip_count  : saturating count of clipped outputs
//   peak_level  : peak-hold magnitude meter (0 unless MIX_LIMITER_PEAK_EN)
module reverb_wet_dry_mixer
    import reverb_pkg::*;
#(
    parameter int unsigned RAMP_STEP    = 1,
    parameter int unsigned MAKEUP_SHIFT = 1,
    parameter int unsigned HOLD_SAMPLES = 4800
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  sample_t       dry_in,
    input  sample_t       wet_in,
    input  mix_t          mix_target,
    input  logic          clip_clear,
    output logic          out_valid,
    output sample_t       audio_out,
    output mix_t          mix_cur,
    output logic          clip,
    output logic [15:0]   clip_count,
    output logic [DW-2:0] peak_level
);

    localparam int unsigned SUM_W = PROD_W + 1;
    localparam int unsigned SHIFT = MIX_W - MAKEUP_SHIFT;

    localparam logic signed [SUM_W-1:0] Y_MAX = SUM_W'(SAT_MAX);
    localparam logic signed [SUM_W-1:0] Y_MIN = SUM_W'(SAT_MIN);

    // Elaboration-time guard on the parameter ranges
    if (MAKEUP_SHIFT > MIX_W || RAMP_STEP == 0 || HOLD_SAMPLES == 0) begin : g_bad_params
        $error("reverb_wet_dry_mixer: illegal parameter value");
    end

    // Mix slew limiter
    mix_gain_ramp u_ramp (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .target   (mix_target),
        .step     (MIX_W'(RAMP_STEP)),
        .mix_cur  (mix_cur)
    );

    // Stage 1: partial products use the mix applied before this sample's update
    logic [MIX_W:0] gain_dry_c;
    prod_t          prod_c;
    prod_t          s1;
    logic           s1_valid;

    always_comb begin
        gain_dry_c   = (MIX_W+1)'(MIX_FULL) - (MIX_W+1)'(mix_cur);
        prod_c.p_dry = PROD_W'(dry_in) * $signed(PROD_W'(gain_dry_c));
        prod_c.p_wet = PROD_W'(wet_in) * $signed(PROD_W'(mix_cur));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1 <= prod_c;
            end
        end
    end

    // Stage 2: sum, floor-shift (arithmetic), saturate
    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] y_c;
    sample_t                 sat_c;
    logic                    clip_c;

    always_comb begin
        sum_c  = SUM_W'(s1.p_dry) + SUM_W'(s1.p_wet);
        y_c    = sum_c >>> SHIFT;
        sat_c  = DW'(y_c);
        clip_c = 1'b0;
        if (y_c > Y_MAX) begin
            sat_c  = DW'(SAT_MAX);
            clip_c = 1'b1;
        end else if (y_c < Y_MIN) begin
            sat_c  = DW'(SAT_MIN);
            clip_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            audio_out <= '0;
            clip      <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            clip      <= s1_valid & clip_c;
            if (s1_valid) begin
                audio_out <= sat_c;
            end
        end
    end

    // Clip event counter, counts each clip pulse; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_count <= '0;
        end else if (clip_clear) begin
            clip_count <= '0;
        end else if (clip && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
        end
    end

`ifdef MIX_LIMITER_PEAK_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_SAMPLES + 1);

    logic [DW-2:0]     mag_c;
    logic [DW-2:0]     peak_r;
    logic [HOLD_W-1:0] hold_cnt;

    // Magnitude of the presented sample; the most negative code folds onto full scale
    always_comb begin
        if (audio_out == sample_t'(SAT_MIN)) begin
            mag_c = '1;
        end else if (audio_out[DW-1]) begin
            mag_c = (DW-1)'(-audio_out);
        end else begin
            mag_c = (DW-1)'(audio_out);
        end
    end

    // Peak hold, then exponential decay by 1/16 per sample once the hold expires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_r   <= '0;
            hold_cnt <= '0;
        end else if (out_valid) begin
            if (mag_c >= peak_r) begin
                peak_r   <= mag_c;
                hold_cnt <= HOLD_W'(HOLD_SAMPLES);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end else begin
                peak_r <= peak_r - (peak_r >> 4);
            end
        end
    end

    assign peak_level = peak_r;
`else
    assign peak_level = '0;
`endif

endmodule

// File: doc/reverb_wet_dry_mixer.md
Name: reverb_wet_dry_mixer

Overview:
- Output stage directly downstream of the FDN reverb.
- Blends the dry input sample with the reverb's wet sample using a 6-bit mix control.
- Ramps the applied mix one step per sample so that control changes do not cause zipper noise.
- Applies fixed make-up gain, saturates to 16 bits and counts clip events. Feeds the codec output path.

Parameters:
- DW, 16, sample width (signed two's complement).
- MIX_W, 6, mix control width; full-scale gain is 2^MIX_W = 64.
- RAMP_STEP, 1, maximum change of the applied mix per valid sample.
- MAKEUP_SHIFT, 1, left shift applied after mixing (compensates reverb halving); legal range 0..MIX_W.
- HOLD_SAMPLES, 4800, peak-hold length in samples (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  one-cycle strobe; dry_in and wet_in are valid this cycle.
- dry_in  in  DW  signed dry sample.
- wet_in  in  DW  signed reverb output sample.
- mix_target  in  MIX_W  requested wet amount; 0 = fully dry, 63 = 63/64 wet.
- clip_clear  in  1  synchronous clear of clip_count.
- out_valid  out  1  one-cycle strobe for audio_out.
- audio_out  out  DW  mixed, saturated sample.
- mix_cur  out  MIX_W  currently applied mix.
- clip  out  1  pulses with out_valid when the current output was saturated.
- clip_count  out  16  number of saturated output samples; sticks at 0xFFFF.
- peak_level  out  DW-1  peak magnitude meter (optional feature).

Behaviour:
- Reset (asynchronous, active-high): all outputs and internal registers go to 0, including mix_cur=0 (fully dry). Any in-flight pipeline data is discarded; out_valid is 0 on the first cycle after reset deasserts.

Stage 1 (cycle of in_valid):
- Compute p_dry = dry_in*(64-mix_cur) and p_wet = wet_in*mix_cur, both signed DW+MIX_W+1 bits, using the pre-update mix_cur, and register them.
- In the same cycle, update mix_cur:
  - mix_cur < mix_target: mix_cur += min(RAMP_STEP, difference).
  - mix_cur > mix_target: mix_cur -= min(RAMP_STEP, difference).
  - Equal: hold.
- mix_cur never overshoots the target.

Stage 2:
- sum = p_dry + p_wet, one extra bit wide.
- y = sum >>> (MIX_W - MAKEUP_SHIFT), arithmetic shift; this floors and does not round.
- Saturate y to [-32768, 32767].
- Register audio_out; assert out_valid and clip (if saturated) for exactly one cycle.

Latency and timing:
- Latency is exactly 2 cycles from in_valid to out_valid.
- Back-to-back in_valid every cycle is supported at full throughput.

Without in_valid:
- mix_cur does not move.
- audio_out holds its last value.
- out_valid and clip are 0.

Clip counter and control changes:
- clip_count increments on each clip pulse and saturates at 0xFFFF.
- clip_clear has priority: clip_clear and clip in the same cycle leave clip_count = 0.
- mix_target is sampled only on in_valid cycles and may change at any time.

Optional Feature:
- Macro MIX_LIMITER_PEAK_EN.
- Defined:
  - On out_valid, m = |audio_out|, with -32768 mapped to 32767.
  - If m >= peak_level: peak_level = m and the hold counter reloads HOLD_SAMPLES.
  - Otherwise, while the hold counter is nonzero it decrements per valid sample.
  - At zero, peak_level -= peak_level>>4 per valid sample; once peak_level < 16 this decay step is 0, so peak_level simply holds.
  - Reset clears peak_level and the counter.
- Not defined: peak_level is constant 0 and no counter logic is generated.

Decomposition:
- Shared package reverb_pkg holds:
  - the sample_t typedef (signed DW);
  - SAT_MAX = 32767 and SAT_MIN = -32768;
  - MIX_FULL = 64.
- One sub-module, mix_gain_ramp, implements the slew-limited mix_cur register (target, in_valid and step in; mix_cur out).

Test Plan:
- Fully dry: after reset, mix_target=0, dry_in=1000, wet_in=-2000, one in_valid -> 2 cycles later out_valid=1, audio_out=2000, clip=0.
- Ramp: mix_target=32 from mix_cur=0 with 40 valid samples spaced 3 cycles apart -> mix_cur increases by 1 per sample, reaches 32 at sample 32 and holds. Idle cycles do not change it.
- Balanced mix with floor: mix_cur=32, dry_in=3, wet_in=-4 -> sum=-32, audio_out=-1; dry_in=1, wet_in=0 -> audio_out=1.
- Saturation: mix_cur=0, dry_in=20000 -> audio_out=32767, clip=1, clip_count=1; dry_in=-20000 -> -32768, clip_count=2. clip_clear on the same cycle as a third clip -> clip_count=0.
- Reset mid-stream: continuous in_valid, assert rst with two samples in flight -> outputs 0 immediately. After release, no out_valid until a new in_valid; first sample has mix_cur=0.
- Peak (MIX_LIMITER_PEAK_EN, HOLD_SAMPLES=4): one output of 16000, then zeros -> peak_level=16000 for 4 samples, then 15000, 14063, ...
